// File: rtl/rf_write_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : rf_write_arbiter                                           |
// | Description : Shares one register-file write port between two writeback |
// |               requesters and keeps a per-register pending scoreboard.   |
// |               Optional: RF_ARB_RR_EN (round-robin ties; else req1 wins). |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module rf_write_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int NREGS  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic              claim_en,
  input  logic [ADDR_W-1:0] claim_addr,
  input  logic [ADDR_W-1:0] chk_addr1,
  input  logic [ADDR_W-1:0] chk_addr2,
  output logic              chk_busy1,
  output logic              chk_busy2,
  output logic [NREGS-1:0]  pending,
  output logic              claim_err,
  output logic              wr_en,
  output logic [ADDR_W-1:0] write_addr,
  output logic [DATA_W-1:0] write_data
);

  logic              grant0;
  logic              grant1;
  logic              wr_en_d,      wr_en_q;
  logic [ADDR_W-1:0] write_addr_d, write_addr_q;
  logic [DATA_W-1:0] write_data_d, write_data_q;
  logic [NREGS-1:0]  pending_d,    pending_q;
  logic              claim_err_d,  claim_err_q;

`ifdef RF_ARB_RR_EN
  // Index of the requester granted most recently; 1 lets req0 win the first tie.
  logic              last_grant_d, last_grant_q;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!reset) begin
      if (req0_valid && req1_valid) begin
        grant0 = last_grant_q;
        grant1 = !last_grant_q;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (grant1) begin
      last_grant_d = 1'b1;
    end else if (grant0) begin
      last_grant_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`else
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!reset) begin
      grant1 = req1_valid;
      grant0 = req0_valid && !req1_valid;
    end
  end
`endif

  always_comb begin
    wr_en_d      = grant0 | grant1;
    write_addr_d = write_addr_q;
    write_data_d = write_data_q;
    if (grant1) begin
      write_addr_d = req1_addr;
      write_data_d = req1_data;
    end else if (grant0) begin
      write_addr_d = req0_addr;
      write_data_d = req0_data;
    end
  end

  // Clear on the commit edge, then apply the claim so a same-address claim wins.
  always_comb begin
    pending_d = pending_q;
    if (wr_en_q) begin
      pending_d[write_addr_q] = 1'b0;
    end
    if (claim_en) begin
      pending_d[claim_addr] = 1'b1;
    end
    claim_err_d = claim_err_q |
                  (claim_en && pending_q[claim_addr] &&
                   !(wr_en_q && (write_addr_q == claim_addr)));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en_q      <= 1'b0;
      write_addr_q <= '0;
      write_data_q <= '0;
      pending_q    <= '0;
      claim_err_q  <= 1'b0;
    end else begin
      wr_en_q      <= wr_en_d;
      write_addr_q <= write_addr_d;
      write_data_q <= write_data_d;
      pending_q    <= pending_d;
      claim_err_q  <= claim_err_d;
    end
  end

  // A write still registered when reset rises must not reach the register file.
  assign wr_en      = wr_en_q & ~reset;
  assign write_addr = write_addr_q;
  assign write_data = write_data_q;
  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign pending    = pending_q;
  assign claim_err  = claim_err_q;
  assign chk_busy1  = pending_q[chk_addr1];
  assign chk_busy2  = pending_q[chk_addr2];

endmodule
`default_nettype wire

// File: tb/tb_rf_write_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_rf_write_arbiter                                        |
// | Description : Directed self-checking bench for rf_write_arbiter.         |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module tb_rf_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [3:0]  req0_addr, req1_addr;
  logic [31:0] req0_data, req1_data;
  logic        claim_en;
  logic [3:0]  claim_addr, chk_addr1, chk_addr2;
  logic        chk_busy1, chk_busy2;
  logic [15:0] pending;
  logic        claim_err, wr_en;
  logic [3:0]  write_addr;
  logic [31:0] write_data;
  logic [31:0] rf_m [16];

  int checks   = 0;
  int failures = 0;

`ifdef RF_ARB_RR_EN
  localparam logic        FIRST_IS_1 = 1'b0;
  localparam logic [3:0]  FIRST_A    = 4'd2;
  localparam logic [31:0] FIRST_D    = 32'hA;
  localparam logic [3:0]  SECOND_A   = 4'd3;
  localparam logic [31:0] SECOND_D   = 32'hB;
`else
  localparam logic        FIRST_IS_1 = 1'b1;
  localparam logic [3:0]  FIRST_A    = 4'd3;
  localparam logic [31:0] FIRST_D    = 32'hB;
  localparam logic [3:0]  SECOND_A   = 4'd2;
  localparam logic [31:0] SECOND_D   = 32'hA;
`endif

  always #5 clk = ~clk;

  // Register-file stand-in fed from the arbiter write port.
  always @(posedge clk) if (wr_en) rf_m[write_addr] <= write_data;

  rf_write_arbiter #(.DATA_W(32), .ADDR_W(4), .NREGS(16)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .claim_en(claim_en), .claim_addr(claim_addr),
    .chk_addr1(chk_addr1), .chk_addr2(chk_addr2), .chk_busy1(chk_busy1), .chk_busy2(chk_busy2),
    .pending(pending), .claim_err(claim_err),
    .wr_en(wr_en), .write_addr(write_addr), .write_data(write_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
    claim_en = 1'b0; claim_addr = '0; chk_addr1 = '0; chk_addr2 = '0;
    tick();
    tick();
    // Reset state, readies blocked while reset is high
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("rst_rdy0", req0_ready, 1'b0);
    check("rst_rdy1", req1_ready, 1'b0);
    check("rst_wr_en", wr_en, 1'b0);
    check("rst_waddr", write_addr, 4'd0);
    check("rst_wdata", write_data, 32'd0);
    check("rst_pending", pending, 16'h0);
    check("rst_claim_err", claim_err, 1'b0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    reset = 1'b0;

    // Single write from req0
    req0_valid = 1'b1; req0_addr = 4'd1; req0_data = 32'd8;
    #1;
    check("t1_rdy0", req0_ready, 1'b1);
    check("t1_rdy1", req1_ready, 1'b0);
    tick();
    req0_valid = 1'b0;
    check("t1_wr_en", wr_en, 1'b1);
    check("t1_waddr", write_addr, 4'd1);
    check("t1_wdata", write_data, 32'd8);
    tick();
    check("t1_wr_en_off", wr_en, 1'b0);
    check("t1_waddr_hold", write_addr, 4'd1);
    check("t1_wdata_hold", write_data, 32'd8);
    check("t1_rf1", rf_m[1], 32'd8);

    // Fresh reset so the tie-break starts from its reset value
    reset = 1'b1;
    tick();
    reset = 1'b0;

    // Contention: both valid and held until granted
    req0_valid = 1'b1; req0_addr = 4'd2; req0_data = 32'hA;
    req1_valid = 1'b1; req1_addr = 4'd3; req1_data = 32'hB;
    #1;
    check("t2_first_rdy0", req0_ready, !FIRST_IS_1);
    check("t2_first_rdy1", req1_ready, FIRST_IS_1);
    tick();
    if (FIRST_IS_1) req1_valid = 1'b0; else req0_valid = 1'b0;
    #1;
    check("t2_wr_en_a", wr_en, 1'b1);
    check("t2_waddr_a", write_addr, FIRST_A);
    check("t2_wdata_a", write_data, FIRST_D);
    check("t2_second_rdy0", req0_ready, FIRST_IS_1);
    check("t2_second_rdy1", req1_ready, !FIRST_IS_1);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("t2_wr_en_b", wr_en, 1'b1);
    check("t2_waddr_b", write_addr, SECOND_A);
    check("t2_wdata_b", write_data, SECOND_D);
    tick();
    check("t2_wr_en_off", wr_en, 1'b0);
    check("t2_rf2", rf_m[2], 32'hA);
    check("t2_rf3", rf_m[3], 32'hB);

    // Scoreboard set / clear through a req1 write
    claim_en = 1'b1; claim_addr = 4'd5; chk_addr1 = 4'd5; chk_addr2 = 4'd5;
    #1;
    check("t3_busy_before", chk_busy1, 1'b0);
    tick();
    claim_en = 1'b0;
    req1_valid = 1'b1; req1_addr = 4'd5; req1_data = 32'h55;
    #1;
    check("t3_busy1_set", chk_busy1, 1'b1);
    check("t3_busy2_set", chk_busy2, 1'b1);
    check("t3_pending", pending, 16'h0020);
    check("t3_rdy1", req1_ready, 1'b1);
    tick();
    req1_valid = 1'b0;
    check("t3_wr_en", wr_en, 1'b1);
    check("t3_busy_in_wr", chk_busy1, 1'b1);
    tick();
    check("t3_busy_clear", chk_busy1, 1'b0);
    check("t3_pending_clear", pending, 16'h0);
    check("t3_rf5", rf_m[5], 32'h55);

    // Claim on the commit edge of the same register: set wins, no error
    claim_en = 1'b1; claim_addr = 4'd7;
    tick();
    claim_en = 1'b0;
    req0_valid = 1'b1; req0_addr = 4'd7; req0_data = 32'h77;
    #1;
    check("t4_pending7", pending, 16'h0080);
    tick();
    req0_valid = 1'b0;
    check("t4_wr_en", wr_en, 1'b1);
    check("t4_waddr", write_addr, 4'd7);
    claim_en = 1'b1; claim_addr = 4'd7;
    tick();
    claim_en = 1'b0;
    check("t4_pending_kept", pending, 16'h0080);
    check("t4_no_err", claim_err, 1'b0);

    // Double claim raises a sticky error
    claim_en = 1'b1; claim_addr = 4'd4;
    tick();
    tick();
    claim_en = 1'b0;
    check("t5_err", claim_err, 1'b1);
    check("t5_pending", pending, 16'h0090);
    repeat (3) tick();
    check("t5_err_sticky", claim_err, 1'b1);

    // Reset right after an accepted transfer drops the write
    req0_valid = 1'b1; req0_addr = 4'd1; req0_data = 32'h66;
    tick();
    reset = 1'b1;
    #1;
    check("t6_wr_en_in_rst", wr_en, 1'b0);
    check("t6_rdy0_in_rst", req0_ready, 1'b0);
    check("t6_rdy1_in_rst", req1_ready, 1'b0);
    tick();
    check("t6_wr_en", wr_en, 1'b0);
    check("t6_pending", pending, 16'h0);
    check("t6_err_clr", claim_err, 1'b0);
    check("t6_rf1_kept", rf_m[1], 32'd8);
    reset = 1'b0;
    #1;
    check("t6_represent", req0_ready, 1'b1);
    tick();
    req0_valid = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
